spi_txn_arbiter: RTL
====================

Name: spi_txn_arbiter

Overview:
- Shares one SPI byte engine (en / mosi_data / data_ready / miso_data contract) between two register-access requesters, e.g. the periodic accelerometer poller and a host configuration port.
- Each granted request is sequenced as one chip-select-framed ADXL362 transaction: command byte, address byte, then data bytes.
- Round-robin arbitration, with an enforced CS-high gap between transactions.

Parameters:
- p_gap_cycles, 10, idle clk cycles with en_o low between transactions (min 1).
- p_cmd_wr, 8'h0A, command byte for register write.
- p_cmd_rd, 8'h0B, command byte for register read.
- p_timeout, 1000, clk cycles allowed per byte before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- req_i  in  2  per-requester request; held high until matching gnt_o
- we_i  in  2  per-requester 1=write, 0=read
- addr_i  in  16  requester n address at [8n+7:8n]
- wdata_i  in  16  requester n write byte at [8n+7:8n]
- len_i  in  6  requester n read length at [3n+2:3n]; bytes = len+1 (1..8); ignored for writes
- gnt_o  out  2  one-cycle pulse, request accepted, inputs latched
- rvalid_o  out  2  one-cycle pulse per read byte to owner
- rdata_o  out  8  read byte, valid with rvalid_o
- done_o  out  2  one-cycle pulse, transaction complete
- err_o  out  1  one-cycle pulse alongside done_o on timeout abort (constant 0 without ARB_TIMEOUT_EN)
- busy_o  out  1  high from grant through end of gap
- en_o  out  1  to byte engine; high frames CS
- mosi_data_o  out  8  byte to transmit
- data_ready_i  in  1  engine pulse, byte shifted; next mosi_data_o must be presented that cycle
- miso_data_i  in  8  received byte, valid with data_ready_i

Behaviour:
- Reset (async, rstn_i=0): all outputs 0.
  - State S_IDLE, gap counter 0, last_owner=1 (requester 0 wins the first tie).
  - Reset mid-transaction drops en_o immediately; no done_o is issued.
- S_IDLE: if req_i!=0, pick a winner.
  - Single requester wins directly; on a tie the requester that is not last_owner wins.
  - Same edge: latch we/addr/wdata/len, gnt_o[winner]<=1, en_o<=1, mosi_data_o<=p_cmd_wr or p_cmd_rd, last_owner<=winner, busy_o<=1, go to S_CMD.
  - Grant latency: 1 cycle from req_i seen.
- S_CMD: on data_ready_i: mosi_data_o<=addr, go to S_ADDR.
- S_ADDR: on data_ready_i: mosi_data_o<= write ? wdata : 8'h00, byte count<=0, go to S_DATA.
- S_DATA: on data_ready_i:
  - Read: rdata_o<=miso_data_i, rvalid_o[owner]<=1.
  - Write, or read with count==len: en_o<=0, done_o[owner]<=1, load gap counter with p_gap_cycles, go to S_GAP.
  - Otherwise: count++, mosi_data_o<=8'h00.
  - miso bytes captured during S_CMD/S_ADDR are discarded.
- S_GAP: decrement the gap counter; on reaching 0, busy_o<=0 and go to S_IDLE. A new grant is possible on the following cycle.
- Request handling:
  - req_i changes during a transaction have no effect.
  - A request dropped before grant is withdrawn.
  - A requester re-asserting immediately after done competes normally and loses the tie to the other requester.
- data_ready_i is ignored in S_IDLE and S_GAP.
- gnt_o, rvalid_o, done_o and err_o are single-cycle registered pulses.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: a per-byte watchdog counts cycles in S_CMD, S_ADDR and S_DATA and reloads on each data_ready_i. On reaching p_timeout: en_o<=0, done_o[owner]<=1, err_o<=1, go to S_GAP.
- Undefined: no watchdog logic; err_o tied to 0; the FSM waits indefinitely for data_ready_i.

Decomposition:
- Package spi_arb_pkg: state enum (S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP), command constants 8'h0A / 8'h0B, the dummy byte 8'h00, and the 3-bit length type.
- Sub-module spi_rr_pick: combinational two-way round-robin selector.
  - Inputs: req[1:0], last_owner.
  - Outputs: valid, winner.

Test Plan:
- Req0 write, addr 8'h2D, wdata 8'h02 -> gnt_o=2'b01 one cycle later; engine sees 8'h0A, 8'h2D, 8'h02 with en_o continuously high; done_o=2'b01 on the third data_ready; en_o low for 10 cycles.
- Req1 read, addr 8'h0E, len 3'd5 (6 bytes), engine returns 8'h11..8'h16 -> six rvalid_o[1] pulses carrying 8'h11..8'h16; MOSI 8'h0B, 8'h0E, then 6×8'h00; done_o[1] on the 6th byte.
- req_i=2'b11 after reset -> req0 served first; req1 granted the first S_IDLE cycle after the gap. Req0 held high throughout -> grants alternate 0,1,0,1.
- rstn_i pulsed low during S_DATA -> en_o, busy_o and all pulses go 0 immediately; no done_o; the next request is granted normally.
- With ARB_TIMEOUT_EN and p_timeout=50, engine withholds data_ready after the command byte -> at cycle 50: en_o=0, done_o[owner]=1, err_o=1; without the macro: en_o stays high and err_o stays 0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP} state_t;

  typedef logic [2:0] len_t;

  localparam logic [7:0] CMD_WR     = 8'h0A;
  localparam logic [7:0] CMD_RD     = 8'h0B;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational two-way round-robin selector; on a tie the requester
// that did not own the engine last wins.
module spi_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (req == 2'b11) ? ~last_owner : req[1];

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin share of one SPI byte engine as CS-framed cmd/addr/data transactions.
// Grant 1 cycle after request; waits on data_ready_i (ARB_TIMEOUT_EN adds a per-byte watchdog).
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int         p_gap_cycles = 10,
  parameter logic [7:0] p_cmd_wr     = CMD_WR,
  parameter logic [7:0] p_cmd_rd     = CMD_RD,
  parameter int         p_timeout    = 1000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic [5:0]  len_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  rvalid_o,
  output logic [7:0]  rdata_o,
  output logic [1:0]  done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        en_o,
  output logic [7:0]  mosi_data_o,
  input  logic        data_ready_i,
  input  logic [7:0]  miso_data_i
);

  localparam int GAP_W = $clog2(p_gap_cycles + 1);

  state_t             state_q, state_nxt;
  logic               owner_q, owner_nxt;
  logic               last_q, last_nxt;
  logic               we_q, we_nxt;
  logic [7:0]         addr_q, addr_nxt;
  logic [7:0]         wdata_q, wdata_nxt;
  len_t               len_q, len_nxt;
  len_t               cnt_q, cnt_nxt;
  logic [GAP_W-1:0]   gap_q, gap_nxt;
  logic [1:0]         gnt_q, gnt_nxt;
  logic [1:0]         rvalid_q, rvalid_nxt;
  logic [7:0]         rdata_q, rdata_nxt;
  logic [1:0]         done_q, done_nxt;
  logic               busy_q, busy_nxt;
  logic               en_q, en_nxt;
  logic [7:0]         mosi_q, mosi_nxt;
  logic               pick_valid, pick_winner;

  spi_rr_pick u_pick (
    .req        (req_i),
    .last_owner (last_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(p_timeout + 1);
  logic [WD_W-1:0] wdog_q, wdog_nxt;
  logic            err_q, err_nxt;
`endif

  always_comb begin
    state_nxt  = state_q;
    owner_nxt  = owner_q;
    last_nxt   = last_q;
    we_nxt     = we_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    len_nxt    = len_q;
    cnt_nxt    = cnt_q;
    gap_nxt    = gap_q;
    gnt_nxt    = 2'b00;
    rvalid_nxt = 2'b00;
    rdata_nxt  = rdata_q;
    done_nxt   = 2'b00;
    busy_nxt   = busy_q;
    en_nxt     = en_q;
    mosi_nxt   = mosi_q;
`ifdef ARB_TIMEOUT_EN
    wdog_nxt   = wdog_q;
    err_nxt    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_nxt = pick_winner;
          last_nxt  = pick_winner;
          we_nxt    = we_i[pick_winner];
          addr_nxt  = pick_winner ? addr_i[15:8]  : addr_i[7:0];
          wdata_nxt = pick_winner ? wdata_i[15:8] : wdata_i[7:0];
          len_nxt   = pick_winner ? len_i[5:3]    : len_i[2:0];
          gnt_nxt   = onehot2(pick_winner);
          en_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          mosi_nxt  = we_i[pick_winner] ? p_cmd_wr : p_cmd_rd;
          state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (data_ready_i) begin
          mosi_nxt  = addr_q;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (data_ready_i) begin
          mosi_nxt  = we_q ? wdata_q : DUMMY_BYTE;
          cnt_nxt   = '0;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (data_ready_i) begin
          if (!we_q) begin
            rdata_nxt  = miso_data_i;
            rvalid_nxt = onehot2(owner_q);
          end
          if (we_q || cnt_q == len_q) begin
            en_nxt    = 1'b0;
            done_nxt  = onehot2(owner_q);
            gap_nxt   = GAP_W'(p_gap_cycles);
            state_nxt = S_GAP;
          end else begin
            cnt_nxt  = cnt_q + len_t'(1);
            mosi_nxt = DUMMY_BYTE;
          end
        end
      end
      S_GAP: begin
        gap_nxt = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    // Watchdog restarts with every grant and every shifted byte.
    if (state_q == S_IDLE) begin
      wdog_nxt = '0;
    end else if (state_q != S_GAP) begin
      if (data_ready_i) begin
        wdog_nxt = '0;
      end else if (wdog_q == WD_W'(p_timeout - 1)) begin
        wdog_nxt  = '0;
        en_nxt    = 1'b0;
        done_nxt  = onehot2(owner_q);
        err_nxt   = 1'b1;
        gap_nxt   = GAP_W'(p_gap_cycles);
        state_nxt = S_GAP;
      end else begin
        wdog_nxt = wdog_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      mosi_q   <= '0;
    end else begin
      state_q  <= state_nxt;
      owner_q  <= owner_nxt;
      last_q   <= last_nxt;
      we_q     <= we_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      len_q    <= len_nxt;
      cnt_q    <= cnt_nxt;
      gap_q    <= gap_nxt;
      gnt_q    <= gnt_nxt;
      rvalid_q <= rvalid_nxt;
      rdata_q  <= rdata_nxt;
      done_q   <= done_nxt;
      busy_q   <= busy_nxt;
      en_q     <= en_nxt;
      mosi_q   <= mosi_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_nxt;
      err_q  <= err_nxt;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign en_o        = en_q;
  assign mosi_data_o = mosi_q;

endmodule
